// File: rtl/gyro_demodulator.sv
// gyro_demodulator
//   Synchronous square-wave demodulator for the fibre-optic gyro loop. The
//   detector samples are multiplied by +1 in the HIGH modulation half and by
//   -1 in the LOW half. Settling samples after each phase edge are dropped.
//   The per-period sums are averaged over 2^shift periods, and the result is
//   sent to the loop filter as one signed error word.
//
// Ports
//   i_clk        clock, all logic on posedge
//   i_rst        synchronous active-high reset
//   i_status     modulation phase (1 = HIGH half, 0 = LOW half)
//   i_adc_valid  i_adc_data qualifies this cycle
//   i_adc_data   signed detector sample, ADC_BIT wide
//   i_skip       valid samples discarded after every phase edge
//   i_avg_shift  log2 of the number of periods averaged per output
//   o_err        signed averaged error, ACC_BIT wide
//   o_err_valid  one-cycle strobe, o_err updated
//   o_sat        some accumulation inside the emitted block clamped
//   o_locked     the first period has been opened by a rising phase edge
module gyro_demodulator #(
  parameter int ADC_BIT  = 14,
  parameter int ACC_BIT  = 32,
  parameter int SKIP_BIT = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_status,
  input  logic                       i_adc_valid,
  input  logic signed [ADC_BIT-1:0]  i_adc_data,
  input  logic        [SKIP_BIT-1:0] i_skip,
  input  logic        [2:0]          i_avg_shift,
  output logic signed [ACC_BIT-1:0]  o_err,
  output logic                       o_err_valid,
  output logic                       o_sat,
  output logic                       o_locked
);

  localparam logic signed [ACC_BIT-1:0] ACC_MAX = {1'b0, {(ACC_BIT-1){1'b1}}};
  localparam logic signed [ACC_BIT-1:0] ACC_MIN = {1'b1, {(ACC_BIT-1){1'b0}}};

  typedef enum logic [1:0] {SYNC, SKIP, ACC} state_t;

  // Saturating add. The MSB of the result flags that clamping took place.
  function automatic logic [ACC_BIT:0] sat_add(input logic signed [ACC_BIT-1:0] a,
                                               input logic signed [ACC_BIT-1:0] b);
    logic signed [ACC_BIT:0] s;
    s = $signed({a[ACC_BIT-1], a}) + $signed({b[ACC_BIT-1], b});
    if (s[ACC_BIT] != s[ACC_BIT-1]) begin
      return {1'b1, (s[ACC_BIT] ? ACC_MIN : ACC_MAX)};
    end
    return {1'b0, s[ACC_BIT-1:0]};
  endfunction

  state_t                     state, state_nx;
  logic                       status_d;
  logic        [SKIP_BIT-1:0] skip_cnt, skip_cnt_nx;
  logic signed [ACC_BIT-1:0]  per_acc, blk_acc;
  logic        [7:0]          per_cnt;
  logic        [2:0]          shift;
  logic                       sat_flag;

  logic                       edge_det, rise, start, take, close, blk_done;
  logic signed [ACC_BIT-1:0]  smp, smp_signed;
  logic        [ACC_BIT:0]    per_sum, blk_sum;
  logic signed [ACC_BIT-1:0]  blk_val;
  logic        [7:0]          per_cnt_inc;

  assign edge_det   = i_status ^ status_d;
  assign rise       = i_status & ~status_d;
  assign smp        = ACC_BIT'(i_adc_data);
  assign smp_signed = i_status ? smp : -smp;

  // start: a new half begins this cycle, and the edge-cycle sample already
  // belongs to it. This sample is either the first skipped one or, when
  // i_skip is zero, the first accumulated one.
  always_comb begin
    state_nx    = state;
    skip_cnt_nx = skip_cnt;
    start       = 1'b0;
    take        = 1'b0;
    case (state)
      SYNC: start = rise;
      SKIP: begin
        if (edge_det) begin
          start = 1'b1;
        end else if (skip_cnt == '0) begin
          state_nx = ACC;
          take     = i_adc_valid;
        end else if (i_adc_valid) begin
          skip_cnt_nx = skip_cnt - 1'b1;
        end
      end
      ACC: begin
        if (edge_det) start = 1'b1;
        else          take  = i_adc_valid;
      end
      default: state_nx = SYNC;
    endcase
    if (start) begin
      if (i_skip == '0) begin
        state_nx    = ACC;
        skip_cnt_nx = '0;
        take        = i_adc_valid;
      end else begin
        state_nx    = SKIP;
        skip_cnt_nx = i_skip - SKIP_BIT'(i_adc_valid);
      end
    end
  end

  // A rise outside SYNC closes the running period (HIGH half then LOW half).
  assign close       = rise && (state != SYNC);
  assign per_sum     = sat_add(per_acc, smp_signed);
  assign blk_sum     = sat_add(blk_acc, per_acc);
  assign blk_val     = blk_sum[ACC_BIT-1:0];
  assign per_cnt_inc = per_cnt + 8'd1;
  assign blk_done    = close && (per_cnt_inc == (8'd1 << shift));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= SYNC;
      status_d    <= 1'b0;
      skip_cnt    <= '0;
      per_acc     <= '0;
      blk_acc     <= '0;
      per_cnt     <= '0;
      shift       <= '0;
      sat_flag    <= 1'b0;
      o_err       <= '0;
      o_err_valid <= 1'b0;
      o_sat       <= 1'b0;
      o_locked    <= 1'b0;
    end else begin
      status_d    <= i_status;
      state       <= state_nx;
      skip_cnt    <= skip_cnt_nx;
      o_err_valid <= 1'b0;

      if (state == SYNC && rise) begin
        o_locked <= 1'b1;
        shift    <= i_avg_shift;
      end

      // A rising edge restarts the period sum with the edge-cycle sample.
      if (rise) begin
        per_acc <= take ? smp_signed : '0;
      end else if (take) begin
        per_acc <= per_sum[ACC_BIT-1:0];
        if (per_sum[ACC_BIT]) sat_flag <= 1'b1;
      end

      if (close) begin
        if (blk_done) begin
          o_err       <= blk_val >>> shift;
          o_err_valid <= 1'b1;
          o_sat       <= sat_flag | blk_sum[ACC_BIT];
          blk_acc     <= '0;
          per_cnt     <= '0;
          sat_flag    <= 1'b0;
          shift       <= i_avg_shift;
        end else begin
          blk_acc <= blk_val;
          per_cnt <= per_cnt_inc;
          if (blk_sum[ACC_BIT]) sat_flag <= 1'b1;
        end
      end
    end
  end

endmodule
